key_sched_bidir: RTL and testbench
==================================

Name:
key_sched_bidir

Overview:
- Sequential AES-128 key schedule; delivers one 128-bit round key per request.
- Runs in both directions:
  - Forward (encrypt): cipher key → round 0..10.
  - Reverse (decrypt): round-10 key → round 10..0, so decryption needs no 176-byte key store.
- Uses one shared forward S-box lookup, byte-serial, one byte per cycle.
- Sits between the key input register and the round datapath; the datapath pulls keys with i_Next.

Parameters:
- none (AES-128 only: 10 rounds, 128-bit key).

Ports:
- i_Clk      in   1    system clock, rising edge
- i_Rst_n    in   1    asynchronous, active-low reset
- i_Start    in   1    load i_Key/i_fDec and begin schedule (1-cycle pulse)
- i_fDec     in   1    0 = forward from cipher key, 1 = reverse from round-10 key; sampled only with i_Start
- i_Key      in   128  cipher key (i_fDec=0) or round-10 key (i_fDec=1); w0 = [127:96]
- i_Next     in   1    request next round key; honoured only while o_Valid=1
- o_RKey     out  128  current round key
- o_Round    out  4    round index of o_RKey (0..10)
- o_Valid    out  1    o_RKey/o_Round valid
- o_Done     out  1    o_Valid=1 and o_Round is the final round (10 fwd, 0 rev)
- o_Busy     out  1    state ≠ IDLE

Behaviour:
- Async reset values: all outputs 0; state IDLE, byte counter 0, key register 0.
- One clock domain; i_Rst_n asserted mid-operation returns to IDLE immediately.

FSM states: IDLE, VALID, SUB, UPD.
- IDLE → VALID on i_Start:
  - key reg ← i_Key; dir ← i_fDec; o_Round ← 0 (fwd) or 10 (rev).
  - o_Valid=1 the cycle after i_Start.
- VALID: holds key/round; o_Valid=1.
  - i_Next=1 and not final → SUB, byte counter=0, o_Valid→0.
  - i_Next=1 at final round → ignored; stay in VALID with o_Done=1. Only i_Start or reset leaves.
- SUB: 4 cycles, byte counter 0..3.
  - Each cycle: one S-box lookup (forward table, decrypt select tied 0 in both directions) on byte k of RotWord(t).
  - Result stored into temp-word byte k.
- UPD: 1 cycle; compute new key and round; then → VALID.
- Latency: i_Next accepted → next o_Valid=1 exactly 5 cycles later.

Word arithmetic:
- Key reg words w0..w3, w0 = MSW.
- RotWord([a0,a1,a2,a3]) = [a1,a2,a3,a0], a0 = MSB.
- Forward, r → r+1:
  - t = w3.
  - w0' = w0 ^ Sub(Rot(t)) ^ {Rcon[r+1],24'h0}.
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- Reverse, r → r−1:
  - w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0.
  - t = w3'.
  - w0' = w0 ^ Sub(Rot(t)) ^ {Rcon[r],24'h0}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (8-bit, no arithmetic; use a lookup).
- Round counter: 4-bit; +1 fwd, −1 rev; never leaves 0..10.

Boundary conditions:
- i_Start in any state (including SUB/UPD): abort, reload, same as from IDLE; i_Next that cycle ignored.
- i_Next while o_Valid=0 is ignored; it is not queued.
- i_fDec changes outside i_Start have no effect.
- o_RKey holds its last value while o_Valid=0; consumers use it only when o_Valid=1.

Test Plan:
- Forward:
  - Stimulus: i_Start, i_fDec=0, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Round 0 = input key.
  - After i_Next: round 1 = a0fafe1788542cb123a339392a6c7605, o_Valid returns 5 cycles after i_Next.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with o_Done=1.
- Reverse:
  - Stimulus: i_Start, i_fDec=1, key d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Stepping yields round 1 = a0fafe17…7605 at o_Round=1, then round 0 = 2b7e1516…4f3c with o_Done=1.
- Final round: i_Next held high at o_Done → o_RKey/o_Round unchanged for 20 cycles, o_Valid stays 1.
- Restart mid-SUB: i_Start with a new key during a SUB cycle → o_Valid 1 cycle later, o_Round=0, o_RKey = new key; no stale update.
- Reset mid-UPD: assert i_Rst_n=0 → all outputs 0 asynchronously; after release, o_Busy=0 until i_Start.
- i_Next while invalid: pulse i_Next during SUB → exactly one round advance total; i_Next held continuously walks 0→10 in 10×6 cycles.

Source files
------------

// File: rtl/key_sched_bidir.sv
// rtl/key_sched_bidir.sv - sequential bidirectional AES-128 key schedule, one byte-serial S-box
module key_sched_bidir (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Start,
  input  logic         i_fDec,
  input  logic [127:0] i_Key,
  input  logic         i_Next,
  output logic [127:0] o_RKey,
  output logic [3:0]   o_Round,
  output logic         o_Valid,
  output logic         o_Done,
  output logic         o_Busy
);

  typedef enum logic [1:0] {IDLE, VALID, SUB, UPD} state_t;

  state_t      state;
  logic        dir;
  logic [1:0]  cnt;
  logic [31:0] temp;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Shared S-box; inv selects the inverse table but the schedule only uses the forward one
  function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
    logic [7:0] v;
    if (inv) begin
      v = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
      return gf_inv(v);
    end
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t_word, rot_word, rc_word;
  logic [7:0]   sub_in, sub_out;
  logic [127:0] next_key;
  logic [3:0]   next_round;
  logic         is_final, next_final;

  assign w0 = o_RKey[127:96];
  assign w1 = o_RKey[95:64];
  assign w2 = o_RKey[63:32];
  assign w3 = o_RKey[31:0];

  // Byte feed for the S-box and the next key/round, evaluated from the held key
  always_comb begin
    t_word   = dir ? (w3 ^ w2) : w3;
    rot_word = {t_word[23:0], t_word[31:24]};
    case (cnt)
      2'd0:    sub_in = rot_word[31:24];
      2'd1:    sub_in = rot_word[23:16];
      2'd2:    sub_in = rot_word[15:8];
      default: sub_in = rot_word[7:0];
    endcase
    sub_out    = sbox(sub_in, 1'b0);
    rc_word    = {rcon(dir ? o_Round : o_Round + 4'd1), 24'h0};
    next_key   = '0;
    if (dir) begin
      next_key[31:0]   = w3 ^ w2;
      next_key[63:32]  = w2 ^ w1;
      next_key[95:64]  = w1 ^ w0;
      next_key[127:96] = w0 ^ temp ^ rc_word;
    end else begin
      next_key[127:96] = w0 ^ temp ^ rc_word;
      next_key[95:64]  = w1 ^ next_key[127:96];
      next_key[63:32]  = w2 ^ next_key[95:64];
      next_key[31:0]   = w3 ^ next_key[63:32];
    end
    next_round = dir ? o_Round - 4'd1 : o_Round + 4'd1;
    is_final   = dir ? (o_Round == 4'd0) : (o_Round == 4'd10);
    next_final = dir ? (next_round == 4'd0) : (next_round == 4'd10);
  end

  // Schedule FSM; i_Start reloads from any state and overrides i_Next
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= IDLE;
      dir     <= 1'b0;
      cnt     <= 2'd0;
      temp    <= '0;
      o_RKey  <= '0;
      o_Round <= 4'd0;
      o_Valid <= 1'b0;
      o_Done  <= 1'b0;
      o_Busy  <= 1'b0;
    end else if (i_Start) begin
      state   <= VALID;
      dir     <= i_fDec;
      cnt     <= 2'd0;
      o_RKey  <= i_Key;
      o_Round <= i_fDec ? 4'd10 : 4'd0;
      o_Valid <= 1'b1;
      o_Done  <= 1'b0;
      o_Busy  <= 1'b1;
    end else begin
      case (state)
        VALID: begin
          if (i_Next && !is_final) begin
            state   <= SUB;
            cnt     <= 2'd0;
            o_Valid <= 1'b0;
            o_Done  <= 1'b0;
          end
        end
        SUB: begin
          case (cnt)
            2'd0:    temp[31:24] <= sub_out;
            2'd1:    temp[23:16] <= sub_out;
            2'd2:    temp[15:8]  <= sub_out;
            default: temp[7:0]   <= sub_out;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= UPD;
        end
        UPD: begin
          o_RKey  <= next_key;
          o_Round <= next_round;
          o_Valid <= 1'b1;
          o_Done  <= next_final;
          state   <= VALID;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sched_bidir.sv
// tb/tb_key_sched_bidir.sv - directed testbench for key_sched_bidir
module tb_key_sched_bidir;

  logic         clk;
  logic         rst_n;
  logic         i_Start;
  logic         i_fDec;
  logic [127:0] i_Key;
  logic         i_Next;
  logic [127:0] o_RKey;
  logic [3:0]   o_Round;
  logic         o_Valid;
  logic         o_Done;
  logic         o_Busy;

  int tests;
  int fails;
  logic [127:0] exp_keys [0:10];

  key_sched_bidir dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Start (i_Start),
    .i_fDec  (i_fDec),
    .i_Key   (i_Key),
    .i_Next  (i_Next),
    .o_RKey  (o_RKey),
    .o_Round (o_Round),
    .o_Valid (o_Valid),
    .o_Done  (o_Done),
    .o_Busy  (o_Busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] k, input logic d);
    i_Start = 1'b1;
    i_fDec  = d;
    i_Key   = k;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic step(output int lat);
    i_Next = 1'b1;
    tick();
    i_Next = 1'b0;
    lat = 0;
    while (!o_Valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({o_RKey, o_Round, o_Valid, o_Done, o_Busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got key=%h round=%0d v=%b d=%b b=%b expected all 0", o_RKey, o_Round, o_Valid, o_Done, o_Busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if (o_Busy !== 1'b0 || o_Valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", o_Busy, o_Valid);
    end
  endtask

  task automatic test_forward;
    int lat;
    start(exp_keys[0], 1'b0);
    i_fDec = 1'b1;
    tests++;
    if (o_Valid !== 1'b1 || o_Round !== 4'd0 || o_RKey !== exp_keys[0] || o_Done !== 1'b0 || o_Busy !== 1'b1) begin
      fails++;
      $display("FAIL fwd_round0: got v=%b r=%0d key=%h d=%b b=%b expected 1 0 %h 0 1", o_Valid, o_Round, o_RKey, o_Done, o_Busy, exp_keys[0]);
    end
    for (int r = 1; r <= 10; r++) begin
      step(lat);
      tests++;
      if (lat !== 5) begin
        fails++;
        $display("FAIL fwd_latency r%0d: got %0d expected 5", r, lat);
      end
      tests++;
      if (o_RKey !== exp_keys[r] || o_Round !== r[3:0] || o_Done !== (r == 10)) begin
        fails++;
        $display("FAIL fwd_key r%0d: got key=%h round=%0d done=%b expected %h %0d %b", r, o_RKey, o_Round, o_Done, exp_keys[r], r, (r == 10));
      end
    end
    i_fDec = 1'b0;
  endtask

  task automatic test_final_hold;
    i_Next = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      tests++;
      if (o_RKey !== exp_keys[10] || o_Round !== 4'd10 || o_Valid !== 1'b1 || o_Done !== 1'b1) begin
        fails++;
        $display("FAIL final_hold c%0d: got key=%h round=%0d v=%b d=%b expected %h 10 1 1", c, o_RKey, o_Round, o_Valid, o_Done, exp_keys[10]);
      end
    end
    i_Next = 1'b0;
  endtask

  task automatic test_reverse;
    int lat;
    start(exp_keys[10], 1'b1);
    tests++;
    if (o_Valid !== 1'b1 || o_Round !== 4'd10 || o_RKey !== exp_keys[10] || o_Done !== 1'b0) begin
      fails++;
      $display("FAIL rev_round10: got v=%b r=%0d key=%h d=%b expected 1 10 %h 0", o_Valid, o_Round, o_RKey, o_Done, exp_keys[10]);
    end
    for (int i = 1; i <= 10; i++) begin
      step(lat);
      tests++;
      if (lat !== 5 || o_RKey !== exp_keys[10 - i] || o_Round !== 4'(10 - i) || o_Done !== (i == 10)) begin
        fails++;
        $display("FAIL rev_key r%0d: got lat=%0d key=%h round=%0d done=%b expected 5 %h %0d %b", 10 - i, lat, o_RKey, o_Round, o_Done, exp_keys[10 - i], 10 - i, (i == 10));
      end
    end
  endtask

  task automatic test_restart_mid_sub;
    int lat;
    start(exp_keys[10], 1'b0);
    i_Next = 1'b1;
    tick();
    i_Next = 1'b0;
    tick();
    i_Next = 1'b1;
    start(exp_keys[0], 1'b0);
    i_Next = 1'b0;
    tests++;
    if (o_Valid !== 1'b1 || o_Round !== 4'd0 || o_RKey !== exp_keys[0]) begin
      fails++;
      $display("FAIL restart_load: got v=%b r=%0d key=%h expected 1 0 %h", o_Valid, o_Round, o_RKey, exp_keys[0]);
    end
    for (int c = 0; c < 6; c++) tick();
    tests++;
    if (o_Valid !== 1'b1 || o_Round !== 4'd0 || o_RKey !== exp_keys[0]) begin
      fails++;
      $display("FAIL restart_stale: got v=%b r=%0d key=%h expected 1 0 %h", o_Valid, o_Round, o_RKey, exp_keys[0]);
    end
    step(lat);
    tests++;
    if (lat !== 5 || o_Round !== 4'd1 || o_RKey !== exp_keys[1]) begin
      fails++;
      $display("FAIL restart_step: got lat=%0d r=%0d key=%h expected 5 1 %h", lat, o_Round, o_RKey, exp_keys[1]);
    end
  endtask

  task automatic test_reset_mid_upd;
    start(exp_keys[0], 1'b0);
    i_Next = 1'b1;
    tick();
    i_Next = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({o_RKey, o_Round, o_Valid, o_Done, o_Busy} !== '0) begin
      fails++;
      $display("FAIL reset_mid_upd: got key=%h round=%0d v=%b d=%b b=%b expected all 0", o_RKey, o_Round, o_Valid, o_Done, o_Busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    tests++;
    if (o_Busy !== 1'b0 || o_Valid !== 1'b0 || o_Round !== 4'd0) begin
      fails++;
      $display("FAIL reset_release: got busy=%b valid=%b round=%0d expected 0 0 0", o_Busy, o_Valid, o_Round);
    end
  endtask

  task automatic test_next_while_invalid;
    int lat;
    start(exp_keys[0], 1'b0);
    i_Next = 1'b1;
    tick();
    i_Next = 1'b0;
    tick();
    i_Next = 1'b1;
    tick();
    i_Next = 1'b0;
    lat = 0;
    while (!o_Valid && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (o_Valid !== 1'b1 || o_Round !== 4'd1 || o_RKey !== exp_keys[1]) begin
      fails++;
      $display("FAIL next_invalid_step: got v=%b r=%0d key=%h expected 1 1 %h", o_Valid, o_Round, o_RKey, exp_keys[1]);
    end
    for (int c = 0; c < 10; c++) tick();
    tests++;
    if (o_Valid !== 1'b1 || o_Round !== 4'd1) begin
      fails++;
      $display("FAIL next_not_queued: got v=%b r=%0d expected 1 1", o_Valid, o_Round);
    end
  endtask

  task automatic test_next_held;
    int n;
    start(exp_keys[0], 1'b0);
    i_Next = 1'b1;
    n = 0;
    while (!o_Done && n < 200) begin
      tick();
      n++;
    end
    i_Next = 1'b0;
    tests++;
    if (n !== 60 || o_Round !== 4'd10 || o_RKey !== exp_keys[10]) begin
      fails++;
      $display("FAIL next_held: got cycles=%0d r=%0d key=%h expected 60 10 %h", n, o_Round, o_RKey, exp_keys[10]);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b1;
    i_Start = 1'b0;
    i_fDec  = 1'b0;
    i_Key   = '0;
    i_Next  = 1'b0;
    exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_forward();
    test_final_hold();
    test_reverse();
    test_restart_mid_sub();
    test_reset_mid_upd();
    test_next_while_invalid();
    test_next_held();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
